// File: rtl/crc32_stream_if.sv
// Beat-stream and result-handshake bundle for crc32_stream.
// master = frame source / result consumer, slave = CRC engine.
interface crc32_stream_if #(
  parameter int DATA_BYTES = 4,
  parameter int CNT_W      = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic [8*DATA_BYTES-1:0] s_data;
  logic [DATA_BYTES-1:0]   s_keep;
  logic                    s_last;
  logic                    crc_valid;
  logic                    crc_ack;
  logic [31:0]             crc_out;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    crc_ok;

  modport master (
    output s_valid, s_data, s_keep, s_last, crc_ack,
    input  s_ready, crc_valid, crc_out, byte_cnt, crc_ok
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last, crc_ack,
    output s_ready, crc_valid, crc_out, byte_cnt, crc_ok
  );
endinterface

// File: rtl/crc32_stream.sv
// Ethernet CRC-32 engine, DATA_BYTES bytes per clock, holds FCS until acknowledged.
// Optional residue check (crc_ok) is built when CRC32_STREAM_CHECK_EN is defined.
module crc32_stream #(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] CRC_POLY   = 32'h04C11DB7,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter int          CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  crc32_stream_if.slave        bus
);

  localparam int NW = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [31:0]      crc_q;
  logic [31:0]      crc_next;
  logic [31:0]      crc_fcs;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   cnt_sum;
  logic [NW-1:0]    n_proc;
  logic             s_ready_q;
  logic             crc_valid_q;
  logic [31:0]      crc_out_q;
  logic             beat_acc;
  logic             last_acc;
  logic             ack_take;

  // Register is kept in normal (non-reflected) form; input bits enter LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign beat_acc = bus.s_valid & s_ready_q;
  assign last_acc = beat_acc & bus.s_last;
  assign ack_take = crc_valid_q & bus.crc_ack;

  // Bytes to process this beat: all of them, or the contiguous keep prefix on the last beat.
  always_comb begin
    logic run;
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    n_proc = '0;
    run    = 1'b1;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (run && (!bus.s_last || bus.s_keep[k])) n_proc = n_proc + NW'(1);
      else                                       run    = 1'b0;
    end
  end

  always_comb begin
    crc_next = crc_q;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (k < int'(n_proc)) crc_next = crc_byte(crc_next, bus.s_data[8*k +: 8]);
    end
  end

  assign crc_fcs  = reflect32(crc_next) ^ XOR_OUT;
  assign cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(n_proc);
  assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_out_q   <= '0;
    end else if (clr) begin
      state       <= RUN;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      s_ready_q   <= 1'b1;
      crc_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= RUN;
          s_ready_q <= 1'b1;
        end
        RUN: begin
          if (beat_acc) begin
            crc_q <= crc_next;
            cnt_q <= cnt_next;
            if (bus.s_last) begin
              state       <= DONE;
              s_ready_q   <= 1'b0;
              crc_valid_q <= 1'b1;
              crc_out_q   <= crc_fcs;
            end
          end
        end
        DONE: begin
          if (ack_take) begin
            state       <= RUN;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            s_ready_q   <= 1'b1;
            crc_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.byte_cnt  = cnt_q;

`ifdef CRC32_STREAM_CHECK_EN
  // A frame carrying its own FCS leaves this fixed value as its final CRC.
  localparam logic [31:0] RESIDUE = 32'h2144DF1C;

  logic crc_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       crc_ok_q <= 1'b0;
    else if (clr)                     crc_ok_q <= 1'b0;
    else if (state == RUN && last_acc) crc_ok_q <= (crc_fcs == RESIDUE);
    else if (ack_take)                crc_ok_q <= 1'b0;
  end

  assign bus.crc_ok = crc_ok_q;
`else
  assign bus.crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream: directed frames on three configurations
// (4 bytes/beat, 4 bytes/beat with 4-bit counter, 1 byte/beat).
module tb_crc32_stream;

`ifdef CRC32_STREAM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] RES = 32'h2144DF1C;

  typedef struct {
    logic [31:0] crc;
    logic [15:0] cnt;
    logic        ok;
    logic        chk_crc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr_aux = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q4[$];
  exp_t qs[$];
  exp_t q1[$];
  logic [2:0] pv = 3'b000;

  always #5 clk = ~clk;

  crc32_stream_if #(.DATA_BYTES(4), .CNT_W(16)) b4 ();
  crc32_stream_if #(.DATA_BYTES(4), .CNT_W(4))  bs ();
  crc32_stream_if #(.DATA_BYTES(1), .CNT_W(16)) b1 ();

  crc32_stream #(.DATA_BYTES(4), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .clr(clr),     .bus(b4));
  crc32_stream #(.DATA_BYTES(4), .CNT_W(4))  u_sat (.clk(clk), .rst_n(rst_n), .clr(clr_aux), .bus(bs));
  crc32_stream #(.DATA_BYTES(1), .CNT_W(16)) u_b1  (.clk(clk), .rst_n(rst_n), .clr(clr_aux), .bus(b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    case (w)
      0:       return b4.s_ready;
      1:       return bs.s_ready;
      default: return b1.s_ready;
    endcase
  endfunction

  function automatic logic cv(input int w);
    case (w)
      0:       return b4.crc_valid;
      1:       return bs.crc_valid;
      default: return b1.crc_valid;
    endcase
  endfunction

  task automatic push(input int w, input logic [31:0] crc, input logic [15:0] cnt,
                      input logic ok, input logic chk_crc);
    exp_t e;
    e.crc = crc; e.cnt = cnt; e.ok = ok; e.chk_crc = chk_crc;
    case (w)
      0:       q4.push_back(e);
      1:       qs.push_back(e);
      default: q1.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int w, input logic [31:0] crc, input logic [15:0] cnt, input logic ok);
    exp_t e;
    int   sz;
    case (w)
      0:       sz = q4.size();
      1:       sz = qs.size();
      default: sz = q1.size();
    endcase
    if (sz == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected[%0d]: result crc %h cnt %0d with nothing expected", w, crc, cnt);
    end else begin
      case (w)
        0:       e = q4.pop_front();
        1:       e = qs.pop_front();
        default: e = q1.pop_front();
      endcase
      if (e.chk_crc) check($sformatf("sb_crc[%0d]", w), crc, e.crc);
      else           check($sformatf("sb_crc_not_residue[%0d]", w), 32'(crc == RES), 32'd0);
      check($sformatf("sb_cnt[%0d]", w), 32'(cnt), 32'(e.cnt));
      check($sformatf("sb_ok[%0d]", w), 32'(ok), 32'(e.ok));
    end
  endtask

  // Monitor: compares each result once, on the cycle crc_valid first appears.
  always @(negedge clk) begin
    if (b4.crc_valid && !pv[0]) pop_check(0, b4.crc_out, b4.byte_cnt, b4.crc_ok);
    if (bs.crc_valid && !pv[1]) pop_check(1, bs.crc_out, 16'(bs.byte_cnt), bs.crc_ok);
    if (b1.crc_valid && !pv[2]) pop_check(2, b1.crc_out, b1.byte_cnt, b1.crc_ok);
    pv <= {b1.crc_valid, bs.crc_valid, b4.crc_valid};
  end

  // Last-beat keep masks must be a contiguous run from bit 0.
  always @(negedge clk) begin
    if (b4.s_valid && b4.s_ready && b4.s_last)
      assert ((b4.s_keep & (b4.s_keep + 1)) == 0)
      else $error("FAIL keep_contiguous: keep %b", b4.s_keep);
    if (bs.s_valid && bs.s_ready && bs.s_last)
      assert ((bs.s_keep & (bs.s_keep + 1)) == 0)
      else $error("FAIL keep_contiguous_sat: keep %b", bs.s_keep);
  end

  // Presents one beat at a negedge and returns on the posedge that accepts it.
  task automatic beat(input int w, input logic [31:0] d, input logic [3:0] k, input logic last);
    int t = 0;
    @(negedge clk);
    case (w)
      0: begin b4.s_valid = 1'b1; b4.s_data = d; b4.s_keep = k; b4.s_last = last; end
      1: begin bs.s_valid = 1'b1; bs.s_data = d; bs.s_keep = k; bs.s_last = last; end
      default: begin b1.s_valid = 1'b1; b1.s_data = d[7:0]; b1.s_keep = k[0]; b1.s_last = last; end
    endcase
    while (!rdy(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check($sformatf("beat_ready_timeout[%0d]", w), 32'(rdy(w)), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int w);
    @(negedge clk);
    case (w)
      0:       b4.s_valid = 1'b0;
      1:       bs.s_valid = 1'b0;
      default: b1.s_valid = 1'b0;
    endcase
  endtask

  task automatic set_ack(input int w, input logic v);
    case (w)
      0:       b4.crc_ack = v;
      1:       bs.crc_ack = v;
      default: b1.crc_ack = v;
    endcase
  endtask

  // Waits for the result (called at a negedge), acknowledges it, checks it clears.
  task automatic take(input int w);
    int t = 0;
    while (!cv(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check($sformatf("result_timeout[%0d]", w), 32'(cv(w)), 32'd1);
    set_ack(w, 1'b1);
    @(negedge clk);
    set_ack(w, 1'b0);
    check($sformatf("ack_clears_valid[%0d]", w), 32'(cv(w)), 32'd0);
  endtask

  task automatic send_t1_4();
    beat(0, 32'h34333231, 4'hF, 1'b0);
    beat(0, 32'h38373635, 4'hF, 1'b0);
    beat(0, 32'h00000039, 4'b0001, 1'b1);
    idle(0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},   32'(b4.s_ready),   32'd0);
    check({tag, "_crc_valid"}, 32'(b4.crc_valid), 32'd0);
    check({tag, "_crc_out"},   b4.crc_out,        32'd0);
    check({tag, "_byte_cnt"},  32'(b4.byte_cnt),  32'd0);
    check({tag, "_crc_ok"},    32'(b4.crc_ok),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b4.s_valid = 0; b4.s_data = '0; b4.s_keep = '0; b4.s_last = 0; b4.crc_ack = 0;
    bs.s_valid = 0; bs.s_data = '0; bs.s_keep = '0; bs.s_last = 0; bs.crc_ack = 0;
    b1.s_valid = 0; b1.s_data = '0; b1.s_keep = '0; b1.s_last = 0; b1.crc_ack = 0;

    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(b4.s_ready), 32'd1);

    // T1: "123456789", result one cycle after the last beat
    push(0, 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    beat(0, 32'h34333231, 4'hF, 1'b0);
    beat(0, 32'h38373635, 4'hF, 1'b0);
    beat(0, 32'h00000039, 4'b0001, 1'b1);
    idle(0);
    check("t1_valid_latency", 32'(b4.crc_valid), 32'd1);
    take(0);

    // T2: four zero bytes, then 'a' (ack pulse while idle must be ignored)
    push(0, RES, 16'd4, CHK, 1'b1);
    beat(0, 32'h00000000, 4'hF, 1'b1);
    idle(0);
    take(0);
    set_ack(0, 1'b1);
    @(negedge clk);
    set_ack(0, 1'b0);
    push(0, 32'hE8B7BE43, 16'd1, 1'b0, 1'b1);
    beat(0, 32'h00000061, 4'b0001, 1'b1);
    idle(0);
    take(0);

    // Last beat with keep=0 closes the frame on the current register
    push(0, RES, 16'd4, CHK, 1'b1);
    beat(0, 32'h00000000, 4'hF, 1'b0);
    beat(0, 32'hDEADBEEF, 4'h0, 1'b1);
    idle(0);
    take(0);

    // T3: result held for 10 cycles with a beat offered; nothing accepted
    push(0, 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    send_t1_4();
    for (int i = 0; i < 10; i++) begin
      b4.s_valid = 1'b1; b4.s_data = 32'h00000061; b4.s_keep = 4'b0001; b4.s_last = 1'b1;
      check("t3_ready_low", 32'(b4.s_ready), 32'd0);
      check("t3_crc_hold",  b4.crc_out,      32'hCBF43926);
      check("t3_cnt_hold",  32'(b4.byte_cnt), 32'd9);
      @(negedge clk);
    end
    b4.s_valid = 1'b0;
    b4.crc_ack = 1'b1;
    @(negedge clk);
    b4.crc_ack = 1'b0;
    check("t3_released", 32'(b4.s_ready), 32'd1);

    // T4: clr mid-frame with a last beat presented alongside (dropped)
    beat(0, 32'h34333231, 4'hF, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    b4.s_data = 32'h38373635; b4.s_keep = 4'hF; b4.s_last = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    b4.s_valid = 1'b0;
    check("clr_cnt",   32'(b4.byte_cnt),  32'd0);
    check("clr_valid", 32'(b4.crc_valid), 32'd0);
    push(0, 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    send_t1_4();
    take(0);

    // rst_n mid-frame: outputs clear at once, then a full frame still works
    beat(0, 32'h34333231, 4'hF, 1'b0);
    @(negedge clk);
    b4.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    send_t1_4();
    take(0);

    // T5: frame including its own FCS, then with a corrupted FCS byte
    push(0, RES, 16'd13, CHK, 1'b1);
    beat(0, 32'h34333231, 4'hF, 1'b0);
    beat(0, 32'h38373635, 4'hF, 1'b0);
    beat(0, 32'hF4392639, 4'hF, 1'b0);
    beat(0, 32'h000000CB, 4'b0001, 1'b1);
    idle(0);
    take(0);
    push(0, 32'h0, 16'd13, 1'b0, 1'b0);
    beat(0, 32'h34333231, 4'hF, 1'b0);
    beat(0, 32'h38373635, 4'hF, 1'b0);
    beat(0, 32'hF4392639, 4'hF, 1'b0);
    beat(0, 32'h000000CA, 4'b0001, 1'b1);
    idle(0);
    take(0);

    // T6: 4-bit counter saturates at 15 over 20 bytes
    push(1, 32'h0, 16'd15, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(1, 32'h04030201 + 32'(i), 4'hF, 1'b0);
      if (i == 2) begin
        #1;
        check("sat_cnt_12", 32'(bs.byte_cnt), 32'd12);
      end
    end
    beat(1, 32'h0A090807, 4'hF, 1'b1);
    idle(1);
    take(1);
    check("sat_cnt_cleared", 32'(bs.byte_cnt), 32'd0);

    // T6: one byte per beat, normal last and keep=0 last
    push(2, 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) beat(2, 32'h31 + 32'(i), 4'b0001, (i == 8));
    idle(2);
    take(2);
    push(2, 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) beat(2, 32'h31 + 32'(i), 4'b0001, 1'b0);
    beat(2, 32'h000000FF, 4'b0000, 1'b1);
    idle(2);
    take(2);

    repeat (3) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("qs_drained", 32'(qs.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
